// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        RULE_ADV  = 2'd0,
        RULE_REP  = 2'd1,
        RULE_RST  = 2'd2,
        RULE_NONE = 2'd3
    } rule_e;

    // Power-on pattern slot i holds (i+1) mod 2^sym_w.
    function automatic int default_sym(input int i, input int sym_w);
        if (sym_w >= 31) return i + 1;
        return (i + 1) & ((1 << sym_w) - 1);
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear.
module seq_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector.sv
// Programmable LEN-symbol pattern detector where each pattern symbol
// may repeat before the next; level flag, hit pulse, saturating count.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int SYM_W = 2,
    parameter int LEN   = 3,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [SYM_W-1:0]        num,
    input  logic                    cfg_we,
    input  logic [$clog2(LEN)-1:0]  cfg_idx,
    input  logic [SYM_W-1:0]        cfg_sym,
    input  logic                    clear,
    output logic                    ans,
    output logic                    hit,
    output logic [CNT_W-1:0]        match_cnt
);

    localparam int P_W = $clog2(LEN + 1);
    localparam logic [P_W-1:0] P_FULL = P_W'(LEN);

    logic [SYM_W-1:0] pat_q [LEN];
    logic [SYM_W-1:0] pat_d [LEN];
    logic [P_W-1:0]   p_q;
    logic [P_W-1:0]   p_d;
    logic [P_W-1:0]   p_sym;
    logic             ans_q;
    logic             ans_d;
    logic             hit_q;
    logic             hit_d;
    logic [SYM_W-1:0] cur_sym;
    logic [SYM_W-1:0] prev_sym;
    rule_e            rule;

    // Expected symbol at p and the one just matched at p-1.
    always_comb begin
        cur_sym  = '0;
        prev_sym = '0;
        for (int i = 0; i < LEN; i++) begin
            if (int'(p_q) == i)     cur_sym  = pat_q[i];
            if (int'(p_q) == i + 1) prev_sym = pat_q[i];
        end
    end

    always_comb begin
        rule = RULE_NONE;
        if (p_q != P_FULL && num == cur_sym) begin
            rule = RULE_ADV;
        end else if (p_q != '0 && num == prev_sym) begin
            rule = RULE_REP;
        end else if (num == pat_q[0]) begin
            rule = RULE_RST;
        end
        unique case (rule)
            RULE_ADV:  p_sym = p_q + P_W'(1);
            RULE_REP:  p_sym = p_q;
            RULE_RST:  p_sym = P_W'(1);
            RULE_NONE: p_sym = '0;
        endcase
    end

    always_comb begin
        pat_d = pat_q;
        p_d   = p_q;
        hit_d = 1'b0;
        if (clear) begin
            p_d = '0;
        end else if (cfg_we) begin
            for (int i = 0; i < LEN; i++) begin
                if (int'(cfg_idx) == i) pat_d[i] = cfg_sym;
            end
            p_d = '0;
        end else if (in_valid) begin
            p_d   = p_sym;
            hit_d = (p_q != P_FULL) && (p_sym == P_FULL);
        end
        ans_d = (p_d == P_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            ans_q <= 1'b0;
            hit_q <= 1'b0;
            for (int i = 0; i < LEN; i++) begin
                pat_q[i] <= SYM_W'(default_sym(i, SYM_W));
            end
        end else begin
            p_q   <= p_d;
            ans_q <= ans_d;
            hit_q <= hit_d;
            pat_q <= pat_d;
        end
    end

    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (hit_d),
        .count (match_cnt)
    );

    assign ans = ans_q;
    assign hit = hit_q;

endmodule

// File: tb/tb_seq_detector.sv
// Directed and random checks of seq_detector against a rule-level model.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] num = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [1:0] cfg_sym = '0;
    logic       clear = 1'b0;
    logic       ans8, hit8, ans2, hit2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int m_pat [4];
    int m_p;
    int m_hit;
    int m_cnt;

    always #5 clk = ~clk;

    seq_detector #(.SYM_W(2), .LEN(3), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
        .clear(clear), .ans(ans8), .hit(hit8), .match_cnt(cnt8)
    );

    seq_detector #(.SYM_W(2), .LEN(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
        .clear(clear), .ans(ans2), .hit(hit2), .match_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) passes++;
        else begin
            fails++;
            $error("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_pat[0] = 1; m_pat[1] = 2; m_pat[2] = 3; m_pat[3] = 0;
        m_p = 0; m_hit = 0; m_cnt = 0;
    endtask

    function automatic int next_p(input int p, input int s);
        if (p < 3 && s == m_pat[p]) return p + 1;
        if (p > 0 && s == m_pat[p - 1]) return p;
        if (s == m_pat[0]) return 1;
        return 0;
    endfunction

    task automatic model_edge(input bit v, input int n, input bit we,
                              input int idx, input int sym, input bit clr);
        int np;
        m_hit = 0;
        if (clr) begin
            m_p = 0; m_cnt = 0;
        end else if (we) begin
            if (idx < 3) m_pat[idx] = sym;
            m_p = 0;
        end else if (v) begin
            np = next_p(m_p, n);
            if (m_p < 3 && np == 3) begin
                m_hit = 1; m_cnt++;
            end
            m_p = np;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ans8"}, 32'(ans8), 32'(m_p == 3));
        chk({tag, ".hit8"}, 32'(hit8), 32'(m_hit));
        chk({tag, ".cnt8"}, 32'(cnt8), 32'(m_cnt > 255 ? 255 : m_cnt));
        chk({tag, ".ans2"}, 32'(ans2), 32'(m_p == 3));
        chk({tag, ".hit2"}, 32'(hit2), 32'(m_hit));
        chk({tag, ".cnt2"}, 32'(cnt2), 32'(m_cnt > 3 ? 3 : m_cnt));
    endtask

    task automatic step(input bit v, input int n, input bit we,
                        input int idx, input int sym, input bit clr,
                        input string tag);
        in_valid = v;
        num      = 2'(n);
        cfg_we   = we;
        cfg_idx  = 2'(idx);
        cfg_sym  = 2'(sym);
        clear    = clr;
        @(posedge clk);
        model_edge(v, n, we, idx, sym, clr);
        #1;
        check_all(tag);
    endtask

    task automatic sym_in(input int n, input string tag);
        step(1'b1, n, 1'b0, 0, 0, 1'b0, tag);
    endtask

    initial begin
        int dflt [7];
        int rpt [4];
        dflt = '{1, 2, 1, 2, 3, 3, 1};
        rpt  = '{1, 1, 2, 2};
        model_reset();

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Default pattern 1,2,3
        foreach (dflt[i]) sym_in(dflt[i], $sformatf("dflt%0d", i));
        chk("dflt_cnt_const", 32'(cnt8), 32'd1);
        chk("dflt_ans_const", 32'(ans8), 32'd0);

        // Repeats with idle gaps
        step(1'b1, 0, 1'b0, 0, 0, 1'b0, "rpt_flush");
        foreach (rpt[i]) sym_in(rpt[i], $sformatf("rpt%0d", i));
        repeat (3) step(1'b0, 3, 1'b0, 0, 0, 1'b0, "idle");
        sym_in(3, "rpt_done");
        chk("rpt_hit_const", 32'(hit8), 32'd1);

        // Reprogram to 3,3,1; first write also presents a valid 3
        step(1'b1, 3, 1'b1, 0, 3, 1'b0, "cfg0");
        step(1'b0, 0, 1'b1, 1, 3, 1'b0, "cfg1");
        step(1'b0, 0, 1'b1, 2, 1, 1'b0, "cfg2");
        sym_in(3, "rp_a");
        step(1'b0, 0, 1'b1, 3, 2, 1'b0, "cfg_oob");
        sym_in(3, "rp0");
        sym_in(3, "rp1");
        sym_in(3, "rp2");
        sym_in(1, "rp3");
        chk("rp_hit_const", 32'(hit8), 32'd1);

        // Clear on the completing symbol
        sym_in(3, "clr_a");
        sym_in(3, "clr_b");
        step(1'b1, 1, 1'b0, 0, 0, 1'b1, "clr_hit");
        chk("clr_cnt_const", 32'(cnt8), 32'd0);

        // Saturation on the narrow counter
        for (int k = 0; k < 5; k++) begin
            sym_in(3, "sat_a");
            sym_in(3, "sat_b");
            sym_in(1, "sat_c");
        end
        chk("sat_cnt2_const", 32'(cnt2), 32'd3);
        chk("sat_cnt8_const", 32'(cnt8), 32'd5);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)
                step(1'b1, int'($urandom_range(0, 3)), 1'b0, 0, 0,
                     1'b1, "rnd_clr");
            else if (r < 8)
                step(($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
                     1'b1, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'b0, "rnd_cfg");
            else
                step(($urandom_range(0, 9) < 8), int'($urandom_range(0, 3)),
                     1'b0, 0, 0, 1'b0, "rnd");
        end

        // Async reset with p=2
        sym_in(m_pat[0], "ar_a");
        sym_in(m_pat[1], "ar_b");
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        sym_in(1, "ar_1");
        sym_in(2, "ar_2");
        sym_in(3, "ar_3");
        chk("ar_hit_const", 32'(hit8), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
